// File: rtl/vec_argmax_pkg.sv
// Shared types and helpers for the streaming arg-max stage.
// T defaults to the layer-family element width.
package vec_argmax_pkg;

    localparam int unsigned DEF_T = 16;

    typedef enum logic [0:0] {
        StCollect = 1'b0,
        StEmit    = 1'b1
    } state_e;

    // Index width for an M-element vector; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned m);
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/argmax_cmp.sv
// Combinational compare/select for the running arg-max.
// The first element of a vector loads unconditionally; later ones must be strictly larger.
module argmax_cmp
    import vec_argmax_pkg::*;
#(
    parameter int unsigned T     = DEF_T,
    parameter int unsigned IDX_W = 3
) (
    input  logic [T-1:0]     cand_val,
    input  logic [IDX_W-1:0] cand_idx,
    input  logic [T-1:0]     run_val,
    input  logic [IDX_W-1:0] run_idx,
    input  logic             first,
    output logic [T-1:0]     next_val,
    output logic [IDX_W-1:0] next_idx
);

    logic take;

    // Strict compare so ties keep the earlier index.
    assign take = first || ($signed(cand_val) > $signed(run_val));

    always_comb begin
        next_val = run_val;
        next_idx = run_idx;
        if (take) begin
            next_val = cand_val;
            next_idx = cand_idx;
        end
    end

endmodule

// File: rtl/vec_argmax.sv
// Streaming arg-max: collects M signed elements, then holds the index/value of the
// largest one on a valid/ready output until accepted.
module vec_argmax
    import vec_argmax_pkg::*;
#(
    parameter int unsigned M = 8,
    parameter int unsigned T = DEF_T,
    localparam int unsigned IDX_W = idx_width(M)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [T-1:0]     data_in,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [IDX_W-1:0] max_idx,
    output logic [T-1:0]     max_val
);

    localparam logic [IDX_W-1:0] LastCnt = IDX_W'(M - 1);

    state_e state_q, state_d;

    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [T-1:0]     run_val_q, run_val_d;
    logic [IDX_W-1:0] run_idx_q, run_idx_d;
    logic [T-1:0]     max_val_q, max_val_d;
    logic [IDX_W-1:0] max_idx_q, max_idx_d;

    logic             accept;
    logic             last;
    logic [T-1:0]     cmp_val;
    logic [IDX_W-1:0] cmp_idx;

    assign accept = s_valid && s_ready;
    assign last   = (cnt_q == LastCnt);

    argmax_cmp #(
        .T     (T),
        .IDX_W (IDX_W)
    ) u_cmp (
        .cand_val (data_in),
        .cand_idx (cnt_q),
        .run_val  (run_val_q),
        .run_idx  (run_idx_q),
        .first    (cnt_q == '0),
        .next_val (cmp_val),
        .next_idx (cmp_idx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StCollect;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StCollect: if (accept && last) state_d = StEmit;
            StEmit:    if (m_valid && m_ready) state_d = StCollect;
            default:   state_d = StCollect;
        endcase
    end

    // Handshake outputs come straight from registered state.
    always_comb begin
        s_ready = 1'b0;
        m_valid = 1'b0;
        unique case (state_q)
            StCollect: s_ready = 1'b1;
            StEmit:    m_valid = 1'b1;
            default:   s_ready = 1'b0;
        endcase
    end

    always_comb begin
        cnt_d     = cnt_q;
        run_val_d = run_val_q;
        run_idx_d = run_idx_q;
        max_val_d = max_val_q;
        max_idx_d = max_idx_q;
        if (accept) begin
            run_val_d = cmp_val;
            run_idx_d = cmp_idx;
            if (last) begin
                cnt_d     = '0;
                max_val_d = cmp_val;
                max_idx_d = cmp_idx;
            end else begin
                cnt_d = cnt_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            run_val_q <= '0;
            run_idx_q <= '0;
            max_val_q <= '0;
            max_idx_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            run_val_q <= run_val_d;
            run_idx_q <= run_idx_d;
            max_val_q <= max_val_d;
            max_idx_q <= max_idx_d;
        end
    end

    assign max_idx = max_idx_q;
    assign max_val = max_val_q;

endmodule

// File: tb/tb_vec_argmax.sv
// Self-checking bench for vec_argmax: directed vectors plus randomized gaps/backpressure
// against an array-based arg-max reference.
module tb_vec_argmax;

    localparam int M = 8;

    logic        clk;
    logic        reset;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] data_in;
    logic        m_valid;
    logic        m_ready;
    logic [2:0]  max_idx;
    logic [15:0] max_val;

    int n_chk;
    int n_bad;
    int hs_cnt;

    vec_argmax #(
        .M (8),
        .T (16)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .data_in (data_in),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .max_idx (max_idx),
        .max_val (max_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset && m_valid && m_ready) hs_cnt <= hs_cnt + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: first element wins, later ones only if strictly larger.
    function automatic void ref_argmax(input int v[M], output int idx, output int val);
        idx = 0;
        val = v[0];
        for (int i = 1; i < M; i++) begin
            if (v[i] > val) begin
                val = v[i];
                idx = i;
            end
        end
    endfunction

    // Sends one vector; duty is the percent chance of s_valid per cycle.
    task automatic send_vec(input int v[M], input int duty, input logic mr);
        int ei, ev, gaps;
        for (int i = 0; i < M; i++) begin
            @(negedge clk);
            m_ready = mr;
            gaps = 0;
            while (($urandom_range(1, 100) > duty) && (gaps < 20)) begin
                s_valid = 1'b0;
                data_in = 16'($urandom);
                gaps++;
                @(negedge clk);
            end
            s_valid = 1'b1;
            data_in = v[i][15:0];
            check("collect_s_ready", int'(s_ready), 1);
            check("collect_m_valid", int'(m_valid), 0);
        end
        @(negedge clk);
        s_valid = 1'b0;
        ref_argmax(v, ei, ev);
        check("latency_m_valid", int'(m_valid), 1);
        check("result_idx", int'(max_idx), ei);
        check("result_val", int'($signed(max_val)), ev);
    endtask

    // Holds m_ready low for `hold` cycles while poking s_valid, then accepts the result.
    task automatic take_result(input int hold, input int ei, input int ev);
        m_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            s_valid = 1'b1;
            data_in = 16'($urandom);
            @(posedge clk);
            @(negedge clk);
            check("hold_m_valid", int'(m_valid), 1);
            check("hold_idx", int'(max_idx), ei);
            check("hold_val", int'($signed(max_val)), ev);
            check("hold_s_ready", int'(s_ready), 0);
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        m_ready = 1'b0;
        check("post_hs_s_ready", int'(s_ready), 1);
        check("post_hs_m_valid", int'(m_valid), 0);
    endtask

    task automatic run_vec(input int v[M], input int duty, input int hold, input logic mr);
        int ei, ev;
        ref_argmax(v, ei, ev);
        send_vec(v, duty, mr);
        take_result(hold, ei, ev);
    endtask

    initial begin
        int v[M];
        int ei, ev, hs_base;

        n_chk   = 0;
        n_bad   = 0;
        hs_cnt  = 0;
        reset   = 1'b1;
        s_valid = 1'b0;
        m_ready = 1'b0;
        data_in = '0;
        repeat (2) @(negedge clk);
        check("rst_s_ready", int'(s_ready), 1);
        check("rst_m_valid", int'(m_valid), 0);
        check("rst_idx", int'(max_idx), 0);
        check("rst_val", int'($signed(max_val)), 0);
        reset = 1'b0;

        // Tie at the maximum, m_ready held high throughout.
        v = '{5, 9, 3, 9, 0, 1, 2, 7};
        run_vec(v, 100, 0, 1'b1);

        // Maximum in the last slot, negatives elsewhere.
        v = '{-3, -1, -7, -2, -8, -5, -4, 100};
        run_vec(v, 100, 0, 1'b0);

        // All most-negative.
        v = '{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768};
        run_vec(v, 100, 0, 1'b0);

        // Backpressure, then a second vector immediately.
        v = '{1, 2, 3, 4, 42, -42, 41, 0};
        run_vec(v, 100, 5, 1'b0);
        v = '{3, 5, 17, -4, 0, 16, 17, 2};
        run_vec(v, 100, 0, 1'b0);

        // Random gaps over three back-to-back vectors.
        hs_base = hs_cnt;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < M; i++) v[i] = int'($urandom_range(0, 20)) - 10;
            run_vec(v, 30, 0, 1'b0);
        end
        check("gap_handshakes", hs_cnt - hs_base, 3);

        // Reset mid-vector after three accepts.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            s_valid = 1'b1;
            data_in = 16'(50 + 10 * i);
        end
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_val", int'($signed(max_val)), 0);
        check("async_rst_s_ready", int'(s_ready), 1);
        reset = 1'b0;
        #1;
        check("rst_rel_m_valid", int'(m_valid), 0);
        check("rst_rel_s_ready", int'(s_ready), 1);
        v = '{1, 2, 3, 4, 5, 6, 7, 8};
        run_vec(v, 100, 0, 1'b0);

        // Random full-range vectors with random gaps and backpressure.
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < M; i++) v[i] = int'($signed(16'($urandom)));
            if (k % 2 == 1) v[$urandom_range(0, M - 1)] = v[$urandom_range(0, M - 1)];
            ref_argmax(v, ei, ev);
            send_vec(v, int'($urandom_range(40, 100)), 1'b0);
            take_result(int'($urandom_range(0, 3)), ei, ev);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/vec_argmax.md
# vec_argmax

Streaming arg-max stage placed directly downstream of the final fully-connected layer. It consumes the M-element output vector, which arrives one element per handshake on a valid/ready stream. It produces the index and value of the largest element as a single classification result. The result is held on a valid/ready output until the consumer accepts it, and the next vector is not accepted until then.

## Interface
- M, 8: elements per input vector (≥2).
- T, 16: signed element width.
- IDX_W, $clog2(M): width of the result index (derived, not overridden).
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- s_valid  in  1  upstream element valid.
- s_ready  out  1  element accepted when s_valid && s_ready.
- data_in  in  T  signed element value.
- m_valid  out  1  result valid.
- m_ready  in  1  downstream accepts result when m_valid && m_ready.
- max_idx  out  IDX_W  index (0-based, arrival order) of the maximum element.
- max_val  out  T  signed value of the maximum element.

## Operation
- State machine with two states: COLLECT and EMIT.
  - COLLECT: s_ready=1, m_valid=0.
  - EMIT: s_ready=0, m_valid=1.
- Element counter `cnt` (0..M-1) counts accepted elements in the current vector.
- On each accept in COLLECT:
  - If cnt==0: the running max is loaded unconditionally (run_val←data_in, run_idx←0). This covers the most-negative value and non-ReLU inputs.
  - Otherwise: update only when $signed(data_in) > run_val, strictly. Ties keep the lower index.
- On the accept with cnt==M-1:
  - The final compare is applied.
  - max_idx/max_val are loaded from the post-compare result.
  - cnt wraps to 0 and state becomes EMIT.
- EMIT: max_idx, max_val and m_valid are held stable while m_ready=0. On m_valid && m_ready, state returns to COLLECT.
- No element is accepted in EMIT, because s_ready=0. Upstream stalls, with data_in held by upstream.
- s_valid gaps in COLLECT: the counter and running max hold. Arbitrary gap lengths are legal.
- Reset values: state=COLLECT, cnt=0, run_val=0, run_idx=0, max_idx=0, max_val=0, m_valid=0, s_ready=1 (s_ready asserts as soon as reset deasserts).
- Reset mid-vector: the partial vector is discarded. The next accepted element is treated as index 0.
- Comparison and storage are full T-bit signed. There is no arithmetic and no overflow.

## Timing
- s_ready and m_valid are decoded directly from registered state, with no combinational path from inputs.
- Latency: m_valid rises the cycle after the M-th element handshake.
- Result handshake to next accept: s_ready rises the cycle after the m_valid && m_ready handshake. The minimum period per vector is therefore M+1 cycles.
- m_ready is ignored in COLLECT.
- s_valid is ignored in EMIT.

## Structure
- Shared package `vec_argmax_pkg` holds:
  - the state enum (COLLECT=0, EMIT=1, 1-bit);
  - a function computing IDX_W from M.
- The layer-family package keeps T as a shared default; this block imports it.
- One natural sub-module, `argmax_cmp`: a combinational compare/select. Its inputs are candidate value/index, running value/index and a `first` flag. Its outputs are the next value/index. The top module holds the FSM, counter and registers.
- Expected size is about 150–200 lines RTL.

## Test plan
- Tie at the maximum. Stimulus: 5,9,3,9,0,1,2,7, m_ready=1. Required: m_valid one cycle after the 8th accept, max_idx=1, max_val=9.
- Maximum in the last slot, and negative values. Stimulus: -3,-1,-7,-2,-8,-5,-4,100. Required: max_idx=7, max_val=100. Then all eight elements -32768: max_idx=0, max_val=-32768.
- Backpressure. Stimulus: a vector with max 42 at index 4, m_ready=0 for 5 cycles. Required: m_valid, max_idx=4 and max_val=42 stable throughout; s_ready=0 and s_valid ignored. After the handshake, s_ready=1 the next cycle and a second vector (max 17 at index 2) gives max_idx=2.
- Input gaps. Stimulus: s_valid toggled randomly at 30% duty over 3 back-to-back vectors. Required: results identical to the gap-free golden model, and exactly 3 output handshakes.
- Reset mid-vector. Stimulus: assert reset (async, between edges) after 3 accepts of 50,60,70. Required: m_valid=0 and s_ready=1 immediately after release. The next vector 1,2,3,4,5,6,7,8 gives max_idx=7, max_val=8.
